seq_alu: RTL and testbench

- Parametrised, handshaked successor to the 20-bit combinational logic/shift/compare circuits.
- Combines logic, arithmetic, shift/rotate and compare ops behind one valid/ready interface.
- Holds a persistent status register (Z, S, C, V) that ADC/SBC consume and the program-flow logic reads and loads.
- Shifts and rotates are iterative, one bit per cycle; everything else completes in a single cycle.

---
 rtl/seq_alu.sv | 188 ++++++++++++++++++
 tb/tb_seq_alu.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: handshaked logic / arithmetic / shift / compare unit with a
// persistent status register.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready high only in IDLE)
//   op, a, b, shamt       opcode, operands, shift/rotate amount
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//   result                registered result
//   flags                 status register {V, S, C, Z}
//   flags_load, flags_in  load the status register (IDLE, no request)
//
// Single-cycle ops register result/flags on the accept edge. Shifts and
// rotates with shamt>0 step one bit per cycle in SHIFT and register
// result/flags on the edge that performs the last bit.
module seq_alu #(
    parameter int WIDTH = 20,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    input  logic             flags_load,
    input  logic [3:0]       flags_in
);

    localparam int M = WIDTH - 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;   // {V, S, C, Z}
    logic [WIDTH-1:0] r_sh;      // shift working register
    logic [SHW-1:0]   r_cnt;     // bits still to shift
    logic [1:0]       r_kind;    // 0 SHR, 1 SHL, 2 ROR, 3 ROL
    logic             r_big;     // shamt >= WIDTH: carry forced to 0

    logic             w_is_shift;
    logic [WIDTH-1:0] w_opb;
    logic             w_ci;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic             w_add_v;
    logic             w_sub_v;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_zsv;
    logic             w_c;
    logic             w_v;
    logic             w_keep;
    logic [3:0]       w_flags;
    logic [WIDTH-1:0] w_step;
    logic             w_step_c;
    logic [3:0]       w_sh_flags;

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign result     = r_result;
    assign flags      = r_flags;
    assign w_is_shift = (op[3:2] == 2'b01);

    // Second operand and carry-in for the add/subtract family
    always_comb begin
        w_opb = b;
        w_ci  = 1'b0;
        case (op)
            4'h9, 4'hB: w_ci  = r_flags[1];
            4'hC, 4'hD: w_opb = {{(WIDTH-1){1'b0}}, 1'b1};
            default: ;
        endcase
    end

    // Bit WIDTH of the sum is the carry; bit WIDTH of the difference is the
    // borrow (the minuend was smaller than subtrahend + carry-in).
    assign w_sum   = {1'b0, a} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_ci};
    assign w_dif   = {1'b0, a} - {1'b0, w_opb} - {{WIDTH{1'b0}}, w_ci};
    assign w_add_v = (a[M] == w_opb[M]) && (w_sum[M] != a[M]);
    assign w_sub_v = (a[M] != w_opb[M]) && (w_dif[M] != a[M]);

    // Single-cycle result; also covers shifts/rotates with shamt=0
    always_comb begin
        w_res  = a;
        w_c    = r_flags[1];
        w_v    = r_flags[3];
        w_keep = 1'b0;
        case (op)
            4'h0: begin w_res = ~a;    w_c = 1'b0; w_v = 1'b0; end
            4'h1: begin w_res = a & b; w_c = 1'b0; w_v = 1'b0; end
            4'h2: begin w_res = a | b; w_c = 1'b0; w_v = 1'b0; end
            4'h3: begin w_res = a ^ b; w_c = 1'b0; w_v = 1'b0; end
            4'h4, 4'h5: w_v = 1'b0;
            4'h8, 4'h9, 4'hC: begin
                w_res = w_sum[M:0]; w_c = w_sum[WIDTH]; w_v = w_add_v;
            end
            4'hA, 4'hB, 4'hD: begin
                w_res = w_dif[M:0]; w_c = w_dif[WIDTH]; w_v = w_sub_v;
            end
            4'hE: begin w_c = w_dif[WIDTH]; w_v = w_sub_v; end
            4'hF: w_keep = 1'b1;
            default: ;
        endcase
    end

    // CMP reports Z/S of the difference while returning a
    assign w_zsv   = (op == 4'hE) ? w_dif[M:0] : w_res;
    assign w_flags = w_keep ? r_flags : {w_v, w_zsv[M], w_c, ~|w_zsv};

    // One bit of shift/rotate per cycle
    always_comb begin
        w_step   = r_sh;
        w_step_c = 1'b0;
        case (r_kind)
            2'd0: begin w_step = {1'b0, r_sh[M:1]};       w_step_c = r_sh[0]; end
            2'd1: begin w_step = {r_sh[M-1:0], 1'b0};     w_step_c = r_sh[M]; end
            2'd2: begin w_step = {r_sh[0], r_sh[M:1]};    w_step_c = r_sh[0]; end
            default: begin w_step = {r_sh[M-1:0], r_sh[M]}; w_step_c = r_sh[M]; end
        endcase
    end

    // Rotates keep C/V; shifts clear V and report the last bit out
    assign w_sh_flags = r_kind[1] ?
        {r_flags[3], w_step[M], r_flags[1], ~|w_step} :
        {1'b0, w_step[M], w_step_c & ~r_big, ~|w_step};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)
                         w_next = (w_is_shift && shamt != '0) ? S_SHIFT : S_DONE;
            S_SHIFT: if (r_cnt == SHW'(1)) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_flags  <= '0;
            r_sh     <= '0;
            r_cnt    <= '0;
            r_kind   <= '0;
            r_big    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_is_shift && shamt != '0) begin
                            r_sh   <= a;
                            r_cnt  <= shamt;
                            r_kind <= op[1:0];
                            r_big  <= (int'(shamt) >= WIDTH);
                        end else begin
                            r_result <= w_res;
                            r_flags  <= w_flags;
                        end
                    end else if (flags_load) begin
                        r_flags <= flags_in;
                    end
                end
                S_SHIFT: begin
                    r_sh  <= w_step;
                    r_cnt <= r_cnt - SHW'(1);
                    if (r_cnt == SHW'(1)) begin
                        r_result <= w_step;
                        r_flags  <= w_sh_flags;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed steps then randomized ops,
// compared against an arithmetic reference model.
module tb_seq_alu;

    localparam int W  = 20;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    op = '0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [SW-1:0] shamt = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic [3:0]    flags;
    logic          flags_load = 1'b0;
    logic [3:0]    flags_in = '0;

    int            ncmp = 0;
    int            nfail = 0;
    logic [3:0]    mflags = '0;

    seq_alu #(.WIDTH(W), .SHW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .shamt(shamt), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flags(flags),
        .flags_load(flags_load), .flags_in(flags_in)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation definitions
    function automatic void model(input logic [3:0] o, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input int n,
                                  input logic [3:0] fi, output logic [W-1:0] r,
                                  output logic [3:0] fo, output int lat);
        longint     two_w = 64'd1 << W;
        longint     ux = longint'(x);
        longint     uy;
        longint     sx;
        longint     sy;
        longint     ci;
        longint     t;
        longint     st;
        logic       c = fi[1];
        logic       v = fi[3];
        logic [W-1:0] zs;
        logic [2*W-1:0] d = {x, x};
        int         k;
        lat = (o >= 4 && o <= 7 && n != 0) ? n + 1 : 1;
        r = x;
        case (o)
            4'h0: begin r = ~x;    c = 0; v = 0; end
            4'h1: begin r = x & y; c = 0; v = 0; end
            4'h2: begin r = x | y; c = 0; v = 0; end
            4'h3: begin r = x ^ y; c = 0; v = 0; end
            4'h4: begin
                v = 0;
                if (n >= W) begin r = '0; c = 0; end
                else if (n > 0) begin r = x >> n; c = x[n-1]; end
            end
            4'h5: begin
                v = 0;
                if (n >= W) begin r = '0; c = 0; end
                else if (n > 0) begin r = x << n; c = x[W-n]; end
            end
            4'h6: begin k = n % W; r = d[k +: W]; end
            4'h7: begin k = n % W; r = d[2*W-1-k -: W]; end
            4'hF: ;
            default: begin
                uy = (o == 4'hC || o == 4'hD) ? 64'd1 : longint'(y);
                ci = (o == 4'h9 || o == 4'hB) ? longint'(fi[1]) : 64'd0;
                sx = x[W-1] ? ux - two_w : ux;
                sy = (uy >= two_w / 2) ? uy - two_w : uy;
                if (o == 4'h8 || o == 4'h9 || o == 4'hC) begin
                    t = ux + uy + ci;  st = sx + sy + ci;
                    c = (t >= two_w);
                end else begin
                    t = ux - uy - ci;  st = sx - sy - ci;
                    c = (t < 0);
                end
                v = (st >= two_w / 2) || (st < -(two_w / 2));
                if (t < 0) t = t + two_w;
                r = W'(t % two_w);
            end
        endcase
        zs = r;
        if (o == 4'hE) begin zs = r; r = x; end
        fo = (o == 4'hF) ? fi : {v, zs[W-1], c, (zs == '0)};
    endfunction

    // Issue one op from IDLE, wait for out_valid, check, then release.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [SW-1:0] n,
                          input bit fl, input int hold, input string tag);
        logic [W-1:0] er;
        logic [3:0]   ef;
        int           el;
        int           lat;
        model(o, x, y, int'(n), mflags, er, ef, el);
        chk({tag, "_rdy"}, in_ready, 1);
        op = o; a = x; b = y; shamt = n; in_valid = 1'b1; out_ready = 1'b0;
        flags_load = fl; flags_in = ~mflags;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; flags_load = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, el);
        chk({tag, "_res"}, result, er);
        chk({tag, "_flg"}, flags, ef);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_res"}, result, er);
            chk({tag, "_hold_flg"}, flags, ef);
            chk({tag, "_hold_rdy"}, in_ready, 0);
            chk({tag, "_hold_vld"}, out_valid, 1);
        end
        mflags = ef;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic load_flags(input logic [3:0] v);
        flags_load = 1'b1; flags_in = v;
        @(negedge clk);
        flags_load = 1'b0;
        chk("flags_load", flags, v);
        mflags = v;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(W-1){1'b0}}};
            3: return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [3:0]    ro;
        logic [SW-1:0] rn;

        repeat (2) @(negedge clk);
        chk("rst_rdy", in_ready, 1);
        chk("rst_vld", out_valid, 0);
        chk("rst_res", result, 0);
        chk("rst_flg", flags, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(4'h8, 20'hFFFFF, 20'h00001, 0, 0, 0, "add_wrap");
        run_op(4'hA, 20'h00003, 20'h00005, 0, 0, 0, "sub_neg");
        run_op(4'hE, 20'h00005, 20'h00005, 0, 0, 0, "cmp_eq");
        load_flags(4'b0010);
        run_op(4'h9, 20'h00010, 20'h00001, 0, 0, 0, "adc_c");
        run_op(4'hB, 20'h00010, 20'h00001, 0, 1, 0, "sbc_fl_ign");
        run_op(4'h5, 20'h80001, 20'h0, 3, 0, 0, "shl3");
        run_op(4'h6, 20'h00001, 20'h0, 1, 0, 0, "ror1");
        run_op(4'h4, 20'h00001, 20'h0, 20, 0, 0, "shr20");
        run_op(4'h5, 20'h00001, 20'h0, 20, 0, 0, "shl20");
        run_op(4'h7, 20'h12345, 20'h0, 0, 0, 0, "rol0");
        run_op(4'h3, 20'hABCDE, 20'h12345, 0, 0, 5, "xor_hold");

        // Reset in the middle of a shift
        op = 4'h4; a = 20'hF0F0F; shamt = 10; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_flg", flags, 0);
        chk("mid_rst_rdy", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        mflags = '0;
        @(negedge clk);

        for (int i = 0; i < 160; i++) begin
            if ($urandom_range(0, 7) == 0) load_flags(4'($urandom));
            ro = 4'($urandom_range(0, 15));
            rn = (ro >= 4 && ro <= 7) ? SW'($urandom_range(0, 31)) : SW'(0);
            run_op(ro, pick(), pick(), rn, ($urandom_range(0, 9) == 0),
                   int'($urandom_range(0, 1)), $sformatf("rnd%0d_op%0h", i, ro));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
